// File: rtl/mux_stream_pkg.sv
// ============================================================================
// Module   : mux_stream_pkg
// Brief    : Shared types for the N-channel stream selector.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mux_stream_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } sel_mode_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first requester at or after ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    localparam logic [IW:0] c_n_chan = (IW+1)'(N);

    logic [IW:0] w_cand;

    // Scan offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_cand    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = {1'b0, ptr} + (IW+1)'(i);
            if (w_cand >= c_n_chan) begin
                w_cand = w_cand - c_n_chan;
            end
            if (req[w_cand[IW-1:0]]) begin
                grant_idx = w_cand[IW-1:0];
                grant_any = 1'b1;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_stream_select.sv
// ============================================================================
// Module   : mux_stream_select
// Brief    : N-channel valid/ready selector (fixed or round-robin) with
//            optional inversion into a single registered output stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_stream_select
    import mux_stream_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [$clog2(N)-1:0] sel,
    input  logic                 invert,
    input  logic [N-1:0]         in_valid,
    input  logic [N*W-1:0]       in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_src,
    input  logic                 out_ready
);

    localparam int          IW       = $clog2(N);
    localparam logic [IW:0] c_n_chan = (IW+1)'(N);

    logic [W-1:0]  w_chan [N];
    logic [N-1:0]  w_rr_grant;
    logic [N-1:0]  w_grant;
    logic [IW-1:0] w_rr_idx;
    logic [IW-1:0] w_gidx;
    logic          w_rr_any;
    logic          w_gany;
    logic          w_sel_ok;
    logic          w_load_en;
    logic          w_xfer;
    sel_mode_t     w_mode;

    out_state_t    state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [IW-1:0] src_q, src_d;
    logic [IW-1:0] ptr_q, ptr_d;

    for (genvar k = 0; k < N; k++) begin : g_chan
        assign w_chan[k] = in_data[k*W +: W];
    end

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_rr (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant     (w_rr_grant),
        .grant_idx (w_rr_idx),
        .grant_any (w_rr_any)
    );

    assign w_mode   = sel_mode_t'(mode);
    assign w_sel_ok = ({1'b0, sel} < c_n_chan) && in_valid[sel];

    always_comb begin
        w_grant = '0;
        w_gidx  = sel;
        w_gany  = 1'b0;
        if (w_mode == MODE_RR) begin
            w_grant = w_rr_grant;
            w_gidx  = w_rr_idx;
            w_gany  = w_rr_any;
        end else if (w_sel_ok) begin
            w_grant[sel] = 1'b1;
            w_gany       = 1'b1;
        end
    end

    // rst_n gates ready so nothing is offered while reset is asserted.
    assign w_load_en = (state_q == ST_EMPTY) || out_ready;
    assign in_ready  = w_grant & {N{w_load_en & rst_n}};
    assign w_xfer    = w_gany & w_load_en & rst_n;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (w_load_en) begin
            state_d = w_xfer ? ST_FULL : ST_EMPTY;
        end
        if (w_xfer) begin
            data_d = invert ? ~w_chan[w_gidx] : w_chan[w_gidx];
            src_d  = w_gidx;
            if (w_mode == MODE_RR) begin
                ptr_d = ({1'b0, w_gidx} == (c_n_chan - 1'b1)) ? '0 : w_gidx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

`default_nettype wire
